// File: rtl/counter_run_ctrl.sv
// Run/pause/stop sequencer around an N-bit up/down counter stepped by a prescaled tick.
// Latency: commands act at the next clk edge; first step TICK_DIV cycles after entering RUN.
module counter_run_ctrl #(
    parameter int N        = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dir_up,
    input  logic         wrap_en,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         running,
    output logic         done,
    output logic [1:0]   state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        cur_state, nxt_state;
    logic [N-1:0]  count_q, count_nxt;
    logic [PW-1:0] presc_q, presc_nxt;

    // The highest-priority asserted command masks all lower ones, even when
    // that command is itself ignored in the current state.
    logic cmd_stop, cmd_start, cmd_load, at_tick;

    assign cmd_stop  = stop & ~clear;
    assign cmd_start = start & ~clear & ~stop;
    assign cmd_load  = load & ~clear & ~stop & ~start;
    assign at_tick   = (cur_state == RUN) && (presc_q == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            count_q   <= '0;
            presc_q   <= '0;
        end else begin
            cur_state <= nxt_state;
            count_q   <= count_nxt;
            presc_q   <= presc_nxt;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        count_nxt = count_q;
        presc_nxt = presc_q;
        if (clear) begin
            nxt_state = IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (cmd_start) begin
                        nxt_state = RUN;
                        presc_nxt = '0;
                    end else if (cmd_load) begin
                        count_nxt = load_val;
                    end
                end
                RUN: begin
                    if (cmd_stop) begin
                        nxt_state = PAUSE;
                    end else if (at_tick) begin
                        presc_nxt = '0;
                        if (dir_up) begin
                            // count above limit is treated as sitting on the bound
                            if (count_q < limit)   count_nxt = count_q + N'(1);
                            else if (wrap_en)      count_nxt = '0;
                            else                   nxt_state = DONE;
                        end else begin
                            if (count_q != '0)     count_nxt = count_q - N'(1);
                            else if (wrap_en)      count_nxt = limit;
                            else                   nxt_state = DONE;
                        end
                    end else begin
                        presc_nxt = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (cmd_start) begin
                        nxt_state = RUN;
                    end else if (cmd_load) begin
                        count_nxt = load_val;
                    end
                end
                DONE: begin
                    if (cmd_start) begin
                        nxt_state = RUN;
                        presc_nxt = '0;
                        count_nxt = dir_up ? '0 : limit;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        count   = count_q;
        state   = cur_state;
        running = (cur_state == RUN);
        done    = (cur_state == DONE);
        tick    = at_tick & ~stop & ~clear & ~reset;
    end

endmodule
